uart_rx_fifo: RTL and testbench

- UART receiver with a byte FIFO on its output. It is the neighbouring stage to uart_tx_fifo and consumes the serial line that uart_tx_fifo drives on o_txp (loopback on the demo board, or an external host).
- Frame format: 8N1, LSB first, idle-high.
- The consumer pops bytes with a one-cycle read handshake.
- Framing errors and FIFO overflow are flagged as 1-cycle pulses.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_core.sv | 136 +++++++++++++
 rtl/uart_rx_fifo.sv | 100 ++++++++++
 tb/tb_uart_rx_fifo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive types, frame constants and baud timing helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Truncating division: the receiver samples on whole clock counts.
  function automatic int clks_per_bit(input int clk_mhz, input int baud);
    longint l_clks;
    l_clks = (longint'(clk_mhz) * 64'sd1_000_000) / longint'(baud);
    return int'(l_clks);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop input synchroniser, mid-bit sampling FSM, LSB-first shift register.
// o_rx_valid / o_frame_err pulse one cycle after the stop-bit sample; there is no backpressure.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 25,
  parameter int BAUD     = 115200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rxp,
  output logic                 o_rx_valid,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_frame_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] FULL_TERM = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  logic                 r_sync1;
  logic                 r_sync2;
  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_armed;
  logic                 r_rx_valid;
  logic                 r_frame_err;

  logic                 w_rx_s;
  rx_state_t            w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_armed_nxt;
  logic                 w_valid_nxt;
  logic                 w_ferr_nxt;

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_armed     <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= i_rxp;
      r_sync2     <= r_sync1;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_armed     <= w_armed_nxt;
      r_rx_valid  <= w_valid_nxt;
      r_frame_err <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_armed_nxt = r_armed;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    unique case (r_state)
      // A start edge only counts once the line has been seen idle-high,
      // so a line stuck low after a framing error cannot open a new frame.
      IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (w_rx_s) begin
          w_armed_nxt = 1'b1;
        end else if (r_armed) begin
          w_armed_nxt = 1'b0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (r_cnt == HALF_TERM) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx_s ? IDLE : DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (r_cnt == FULL_TERM) begin
          w_cnt_nxt              = '0;
          w_shift_nxt[r_bit_idx] = w_rx_s;
          if (r_bit_idx == LAST_IDX) begin
            w_idx_nxt   = '0;
            w_state_nxt = STOP;
          end else begin
            w_idx_nxt = r_bit_idx + IDX_ONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      STOP: begin
        if (r_cnt == FULL_TERM) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
          w_valid_nxt = w_rx_s;
          w_ferr_nxt  = ~w_rx_s;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The shift register is not touched again until the next frame's first data
  // sample, so it can drive the byte alongside the valid pulse directly.
  assign o_rx_valid  = r_rx_valid;
  assign o_rx_data   = r_shift;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver feeding a DEPTH-entry byte FIFO; the write lands one cycle after the stop sample, reads are 1-cycle.
// No backpressure to the line: a byte arriving while full (and not being read) is dropped with an overflow pulse.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 25,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_rxp,
  input  logic                       rd_en,
  output logic [7:0]                 rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       frame_err,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic                 w_rx_valid;
  logic [DATA_BITS-1:0] w_rx_data;
  logic                 w_frame_err;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_W-1:0]     r_count;
  logic [7:0]           r_rd_data;
  logic                 r_overflow;

  logic w_full;
  logic w_empty;
  logic w_rd;
  logic w_wr;
  logic w_drop;

  uart_rx_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rxp       (i_rxp),
    .o_rx_valid  (w_rx_valid),
    .o_rx_data   (w_rx_data),
    .o_frame_err (w_frame_err)
  );

  assign w_full  = (r_count == FULL_LVL);
  assign w_empty = (r_count == '0);
  assign w_rd    = rd_en && !w_empty;
  // A same-cycle read frees the head slot, so a write into a full FIFO is still taken.
  assign w_wr    = w_rx_valid && (!w_full || w_rd);
  assign w_drop  = w_rx_valid && w_full && !w_rd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_rd) begin
        r_rptr    <= r_rptr + PTR_ONE;
        r_rd_data <= r_mem[r_rptr];
      end
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      r_overflow <= w_drop;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= w_rx_data;
    end
  end

  assign rd_data   = r_rd_data;
  assign empty     = w_empty;
  assign count     = r_count;
  assign frame_err = w_frame_err;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboarded bench for uart_rx_fifo: serial frames are bit-banged on i_rxp and a queue model of the FIFO predicts pops.
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 25;
  localparam int BAUD     = 115200;
  localparam int DEPTH    = 16;
  localparam int CPB      = (CLK_FREQ * 1_000_000) / BAUD;
  localparam int HALF     = CPB / 2;
  localparam int CW       = $clog2(DEPTH + 1);
  // Start edge to write edge: 2 sync flops + idle detect + half bit + 9 bit periods + write cycle.
  localparam int WR_LAT   = 4 + HALF + 9 * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_rxp = 1'b1;
  logic          rd_en = 1'b0;
  logic [7:0]    rd_data;
  logic          empty;
  logic [CW-1:0] count;
  logic          frame_err;
  logic          overflow;

  uart_rx_fifo #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rxp     (i_rxp),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .count     (count),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  int n_ferr = 0;
  int n_ovf = 0;
  int exp_ferr = 0;
  int exp_ovf = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic       rd_fire = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_fire <= rd_en && !empty;
  end

  // Monitor: pulse counting and pop checking, independent of the stimulus flow.
  always @(negedge clk) begin
    if (frame_err) n_ferr++;
    if (overflow) n_ovf++;
    if (rd_fire) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'(rd_data), 32'hFFFF_FFFF);
      end else begin
        chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic v);
    i_rxp = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    i_rxp = 1'b1;
    if (!stop_ok) exp_ferr++;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else exp_ovf++;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_level(input string name);
    chk({name, "_count"}, 32'(count), 32'(model_q.size()));
    chk({name, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_rd_data"}, 32'(rd_data), 32'h00);
    chk({name, "_empty"}, 32'(empty), 32'h1);
    chk({name, "_count"}, 32'(count), 32'h0);
    chk({name, "_frame_err"}, 32'(frame_err), 32'h0);
    chk({name, "_overflow"}, 32'(overflow), 32'h0);
  endtask

  initial begin
    int k;
    int target;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte with exact write latency
    fork
      send_frame(8'h55, 1'b1);
      begin
        k = 0;
        @(negedge clk);
        while (empty && k < 12 * CPB) begin
          @(negedge clk);
          k++;
        end
        chk("empty_fall_latency", 32'(cyc - t0), 32'(WR_LAT));
      end
    join
    chk("single_count", 32'(count), 32'd1);
    pop();
    check_level("single_after_pop");
    pop();
    chk("rd_hold_when_empty", 32'(rd_data), 32'h55);
    check_level("empty_read");

    // Back-to-back frames with no idle gap
    send_frame(8'hA5, 1'b1);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    check_level("b2b");
    repeat (3) pop();
    check_level("b2b_drained");
    chk("b2b_ferr", 32'(n_ferr), 32'(exp_ferr));
    chk("b2b_ovf", 32'(n_ovf), 32'(exp_ovf));

    // Short low glitch: false start
    i_rxp = 1'b0;
    repeat (50) @(negedge clk);
    i_rxp = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_level("glitch");
    chk("glitch_ferr", 32'(n_ferr), 32'd0);

    // Framing error then a good frame
    send_frame(8'h3C, 1'b0);
    repeat (CPB) @(negedge clk);
    chk("ferr_pulses", 32'(n_ferr), 32'(exp_ferr));
    check_level("ferr");
    send_frame(8'h3C, 1'b1);
    check_level("after_ferr");
    pop();

    // Fill past full
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b1);
    chk("ovf_pulses", 32'(n_ovf), 32'(exp_ovf));
    chk("ovf_count", 32'(count), 32'(DEPTH));

    // Write while full with a read on the same edge: accepted, no overflow
    fork
      send_frame(8'h11, 1'b1);
      begin
        @(negedge clk);
        target = t0 + WR_LAT - 1;
        k = 0;
        while (cyc < target && k < 12 * CPB) begin
          @(negedge clk);
          k++;
        end
        rd_en = 1'b1;
        exp_q.push_back(model_q.pop_front());
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    chk("full_rw_ovf", 32'(n_ovf), 32'(exp_ovf));
    check_level("full_rw");
    repeat (DEPTH) pop();
    check_level("ovf_drained");

    // Random bytes queued, then reset in the middle of data bit 4 of 0x81
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
    end
    check_level("prequeue");
    b = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    i_rxp = b[4];
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    i_rxp = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("midframe_rst");
    rst_n = 1'b1;
    model_q.delete();
    repeat (CPB) @(negedge clk);
    check_level("post_rst");
    send_frame(8'h81, 1'b1);
    check_level("post_rst_frame");
    pop();

    // Randomised frames with random reads interleaved
    for (int i = 0; i < 3; i++) begin
      send_frame(8'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) pop();
      check_level("rand");
    end
    while (model_q.size() > 0) pop();
    check_level("final");
    chk("final_ferr", 32'(n_ferr), 32'(exp_ferr));
    chk("final_ovf", 32'(n_ovf), 32'(exp_ovf));
    chk("pending_pops", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
